seq_checker: RTL and testbench

- Receiving end of the two-symbol sequence link. The sequence generator drives a 2-bit symbol stream that alternates 1, 2, 1, 2, ...
- This block samples that stream, locks onto the alternation, counts good pairs and protocol errors, and reports lock status.
- It sits directly on the generator's 2-bit output bus, qualified by a valid strobe.

---
 rtl/seq_checker.sv | 144 ++++++++++++++
 tb/tb_seq_checker.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/seq_checker.sv
// Receiver for the alternating 1,2 symbol link: aligns to the pair boundary,
// counts good pairs and bad symbols, and tracks lock with hysteresis.
module seq_checker #(
  parameter int CNT_W      = 8,
  parameter int LOCK_PAIRS = 2,
  parameter int ERR_LIMIT  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [1:0]       entrada,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] pair_count,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    EXP2   = 2'd1,
    EXP1   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);
  localparam logic [3:0]       LOCK_N  = 4'(LOCK_PAIRS);
  localparam logic [3:0]       ERR_N   = 4'(ERR_LIMIT);

  state_t           state_r, state_s;
  logic             locked_r, locked_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] pair_cnt_r, pair_cnt_s;
  logic [CNT_W-1:0] err_cnt_r, err_cnt_s;
  logic [3:0]       good_run_r, good_run_s;
  logic [3:0]       bad_run_r, bad_run_s;
  logic             pair_hit_s;
  logic             err_hit_s;

  // Next-state decode and counter/lock updates for the current sample
  always_comb begin
    state_s    = state_r;
    locked_s   = locked_r;
    err_s      = 1'b0;
    pair_cnt_s = pair_cnt_r;
    err_cnt_s  = err_cnt_r;
    good_run_s = good_run_r;
    bad_run_s  = bad_run_r;
    pair_hit_s = 1'b0;
    err_hit_s  = 1'b0;

    if (valid) begin
      case (state_r)
        SEARCH: begin
          // Anything but a 1 is noise while hunting for alignment
          if (entrada == 2'd1) begin
            state_s = EXP2;
          end else begin
            state_s = SEARCH;
          end
        end
        EXP2: begin
          case (entrada)
            2'd2: begin
              state_s    = EXP1;
              pair_hit_s = 1'b1;
            end
            2'd1: begin
              state_s   = EXP2;
              err_hit_s = 1'b1;
            end
            default: begin
              state_s   = SEARCH;
              err_hit_s = 1'b1;
            end
          endcase
        end
        EXP1: begin
          if (entrada == 2'd1) begin
            state_s   = EXP2;
            bad_run_s = 4'd0;
          end else begin
            state_s   = SEARCH;
            err_hit_s = 1'b1;
          end
        end
        default: begin
          state_s = SEARCH;
        end
      endcase
    end else begin
      state_s = state_r;
    end

    if (pair_hit_s) begin
      pair_cnt_s = (pair_cnt_r == CNT_MAX) ? CNT_MAX : pair_cnt_r + CNT_ONE;
      good_run_s = (good_run_r >= LOCK_N) ? LOCK_N : good_run_r + 4'd1;
      bad_run_s  = 4'd0;
      if (good_run_s == LOCK_N) begin
        locked_s = 1'b1;
      end else begin
        locked_s = locked_r;
      end
    end else if (err_hit_s) begin
      err_s      = 1'b1;
      err_cnt_s  = (err_cnt_r == CNT_MAX) ? CNT_MAX : err_cnt_r + CNT_ONE;
      good_run_s = 4'd0;
      bad_run_s  = (bad_run_r >= ERR_N) ? ERR_N : bad_run_r + 4'd1;
      if (bad_run_s == ERR_N) begin
        locked_s = 1'b0;
      end else begin
        locked_s = locked_r;
      end
    end else begin
      locked_s = locked_r;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= SEARCH;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      pair_cnt_r <= '0;
      err_cnt_r  <= '0;
      good_run_r <= 4'd0;
      bad_run_r  <= 4'd0;
    end else begin
      state_r    <= state_s;
      locked_r   <= locked_s;
      err_r      <= err_s;
      pair_cnt_r <= pair_cnt_s;
      err_cnt_r  <= err_cnt_s;
      good_run_r <= good_run_s;
      bad_run_r  <= bad_run_s;
    end
  end

  assign locked     = locked_r;
  assign err        = err_r;
  assign pair_count = pair_cnt_r;
  assign err_count  = err_cnt_r;

endmodule

// File: tb/tb_seq_checker.sv
// Scoreboard bench for seq_checker: stimulus queues hand-computed expectations,
// a monitor pops one per sampled symbol and compares both counter widths.
module tb_seq_checker;

  typedef struct {
    logic l;
    logic e;
    int   pc;
    int   ec;
    string tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [1:0] entrada;
  logic       locked, err;
  logic [7:0] pair_count, err_count;
  logic       locked2, err2;
  logic [1:0] pair_count2, err_count2;

  exp_t exp_q[$];
  int   checks;
  int   errors;

  seq_checker #(.CNT_W(8), .LOCK_PAIRS(2), .ERR_LIMIT(3)) dut (
    .clk(clk), .rst(rst), .valid(valid), .entrada(entrada),
    .locked(locked), .err(err), .pair_count(pair_count), .err_count(err_count)
  );

  seq_checker #(.CNT_W(2), .LOCK_PAIRS(2), .ERR_LIMIT(3)) dut2 (
    .clk(clk), .rst(rst), .valid(valid), .entrada(entrada),
    .locked(locked2), .err(err2), .pair_count(pair_count2), .err_count(err_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  task automatic chk_all(input string tag, input logic l, input logic e, input int pc, input int ec);
    chk({tag, ".locked"}, int'(locked), int'(l));
    chk({tag, ".err"}, int'(err), int'(e));
    chk({tag, ".pair_count"}, int'(pair_count), pc);
    chk({tag, ".err_count"}, int'(err_count), ec);
    chk({tag, ".locked_w2"}, int'(locked2), int'(l));
    chk({tag, ".pair_count_w2"}, int'(pair_count2), sat3(pc));
    chk({tag, ".err_count_w2"}, int'(err_count2), sat3(ec));
  endtask

  // Drive one sample and queue what must be visible after the edge that takes it
  task automatic send(input string tag, input logic v, input logic [1:0] e,
                      input logic xl, input logic xe, input int xpc, input int xec);
    exp_t x;
    valid   = v;
    entrada = e;
    x.l = xl; x.e = xe; x.pc = xpc; x.ec = xec; x.tag = tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // Monitor: every edge that consumed a queued sample gets compared
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        #2;
        chk_all(x.tag, x.l, x.e, x.pc, x.ec);
      end
    end
  end

  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b0;
    valid   = 1'b0;
    entrada = 2'd0;
    #1;
    chk_all("reset", 1'b0, 1'b0, 0, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;

    // Alignment: post-reset zeros ignored, lock after second pair
    send("t1_0a", 1'b1, 2'd0, 1'b0, 1'b0, 0, 0);
    send("t1_0b", 1'b1, 2'd0, 1'b0, 1'b0, 0, 0);
    send("t1_1a", 1'b1, 2'd1, 1'b0, 1'b0, 0, 0);
    send("t1_2a", 1'b1, 2'd2, 1'b0, 1'b0, 1, 0);
    send("t1_1b", 1'b1, 2'd1, 1'b0, 1'b0, 1, 0);
    send("t1_2b", 1'b1, 2'd2, 1'b1, 1'b0, 2, 0);

    // Isolated repeated 1 while locked: resync, lock held
    send("t2_1a", 1'b1, 2'd1, 1'b1, 1'b0, 2, 0);
    send("t2_2a", 1'b1, 2'd2, 1'b1, 1'b0, 3, 0);
    send("t2_1b", 1'b1, 2'd1, 1'b1, 1'b0, 3, 0);
    send("t2_1c", 1'b1, 2'd1, 1'b1, 1'b1, 3, 1);
    send("t2_2b", 1'b1, 2'd2, 1'b1, 1'b0, 4, 1);

    // valid gaps: garbage on entrada while valid is low is ignored
    send("t4_1", 1'b1, 2'd1, 1'b1, 1'b0, 4, 1);
    send("t4_x1", 1'b0, 2'd3, 1'b1, 1'b0, 4, 1);
    send("t4_2", 1'b1, 2'd2, 1'b1, 1'b0, 5, 1);
    send("t4_x2", 1'b0, 2'd0, 1'b1, 1'b0, 5, 1);

    // Three consecutive errors drop lock, then fall back to SEARCH
    send("t3_1", 1'b1, 2'd1, 1'b1, 1'b0, 5, 1);
    send("t3_e1", 1'b1, 2'd1, 1'b1, 1'b1, 5, 2);
    send("t3_e2", 1'b1, 2'd1, 1'b1, 1'b1, 5, 3);
    send("t3_e3", 1'b1, 2'd1, 1'b0, 1'b1, 5, 4);
    send("t3_e4", 1'b1, 2'd3, 1'b0, 1'b1, 5, 5);
    send("t3_s0", 1'b1, 2'd0, 1'b0, 1'b0, 5, 5);
    send("t3_s3", 1'b1, 2'd3, 1'b0, 1'b0, 5, 5);

    // Asynchronous reset mid-pair, then a lone 2 is ignored in SEARCH
    send("t6_1", 1'b1, 2'd1, 1'b0, 1'b0, 5, 5);
    valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_all("t6_async", 1'b0, 1'b0, 0, 0);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk);
    #1;
    send("t6_2", 1'b1, 2'd2, 1'b0, 1'b0, 0, 0);
    send("t6_1b", 1'b1, 2'd1, 1'b0, 1'b0, 0, 0);
    send("t6_2b", 1'b1, 2'd2, 1'b0, 1'b0, 1, 0);
    valid = 1'b0;

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
